// File: rtl/mem_port_arbiter_if.sv
// Port-B sharing bus between the two requesters, the arbiter and the block memory.
// The arbiter takes the slave view; requesters plus the memory take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_q,
    output gnt0, rvalid0, gnt1, rvalid1,
    output rdata, mem_we, mem_addr, mem_din
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_q,
    input  gnt0, rvalid0, gnt1, rvalid1,
    input  rdata, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with a burst limit sharing memory port B between r0 and r1.
// Grants are combinational; read-valid strobes follow a read grant by one cycle.
module mem_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);
  localparam int              CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              gnt0, gnt1;
  logic              burst_open;

  assign burst_open = (burst_cnt_q < BURST_MAX);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case ({bus.req1, bus.req0})
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        2'b11: begin
          case (state_q)
            OWN0: begin
              gnt0 = burst_open;
              gnt1 = !burst_open;
            end
            OWN1: begin
              gnt1 = burst_open;
              gnt0 = !burst_open;
            end
            default: begin
              gnt0 = last_owner_q;
              gnt1 = !last_owner_q;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    if (gnt0) begin
      bus.mem_we   = bus.we0;
      bus.mem_addr = bus.addr0;
      bus.mem_din  = bus.wdata0;
    end else if (gnt1) begin
      bus.mem_we   = bus.we1;
      bus.mem_addr = bus.addr1;
      bus.mem_din  = bus.wdata1;
    end
  end

  // A run is restarted whenever ownership changes; it saturates once the limit is hit.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    rvalid0_d    = gnt0 & ~bus.we0;
    rvalid1_d    = gnt1 & ~bus.we1;
    if (gnt0) begin
      last_owner_d = 1'b0;
      if (state_q != OWN0) begin
        state_d     = OWN0;
        burst_cnt_d = CNT_ONE;
      end else if (burst_open) begin
        burst_cnt_d = burst_cnt_q + CNT_ONE;
      end
    end else if (gnt1) begin
      last_owner_d = 1'b1;
      if (state_q != OWN1) begin
        state_d     = OWN1;
        burst_cnt_d = CNT_ONE;
      end else if (burst_open) begin
        burst_cnt_d = burst_cnt_q + CNT_ONE;
      end
    end else begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  // Gating with reset drops a read result that would otherwise land during reset.
  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q & ~reset;
  assign bus.rvalid1 = rvalid1_q & ~reset;
  assign bus.rdata   = bus.mem_q;

  a_gnt_onehot: assert property (@(posedge clk) !(gnt0 && gnt1));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for reset and
// ownership corners, then constrained-random traffic against a run-length reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Behavioural block memory: synchronous read, one cycle latency
  logic [DATA_W-1:0] ram [1024];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_q <= ram[bus.mem_addr];
  end

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Currently driven stimulus
  bit dRst, dR0, dW0, dR1, dW1;
  logic [ADDR_W-1:0] dA0, dA1;
  logic [DATA_W-1:0] dD0, dD1;

  // Reference model: last owner, current run (grantee and length), pending read
  int mLast = 1;
  int mPrev = -1;
  int mStreak = 0;
  int mPend = -1;
  bit mPendKnown = 0;
  logic [DATA_W-1:0] mPendData = '0;
  logic [DATA_W-1:0] refMem [int];

  function automatic int refGrant();
    if (dRst) return -1;
    if (dR0 && !dR1) return 0;
    if (dR1 && !dR0) return 1;
    if (!dR0 && !dR1) return -1;
    if (mPrev < 0) return 1 - mLast;
    if (mStreak < MAX_BURST) return mPrev;
    return 1 - mPrev;
  endfunction

  task automatic applyStimulus(input bit rst, input bit r0, input bit w0, input int a0, input int d0,
                               input bit r1, input bit w1, input int a1, input int d1);
    dRst = rst; dR0 = r0; dW0 = w0; dA0 = ADDR_W'(a0); dD0 = DATA_W'(d0);
    dR1 = r1; dW1 = w1; dA1 = ADDR_W'(a1); dD1 = DATA_W'(d1);
    reset = rst;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = dA0; bus.wdata0 = dD0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = dA1; bus.wdata1 = dD1;
    @(negedge clk);
  endtask

  task automatic endCycle();
    int g;
    logic w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    g = refGrant();
    w = 1'b0; a = '0; d = '0;
    if (g == 0) begin w = dW0; a = dA0; d = dD0; end
    else if (g == 1) begin w = dW1; a = dA1; d = dD1; end
    mPend = -1;
    if (dRst) begin
      mLast = 1; mPrev = -1; mStreak = 0;
    end else if (g >= 0) begin
      if (w) refMem[int'(a)] = d;
      else begin
        mPend = g;
        mPendKnown = refMem.exists(int'(a));
        if (mPendKnown) mPendData = refMem[int'(a)];
      end
      mStreak = (g == mPrev) ? mStreak + 1 : 1;
      mPrev = g;
      mLast = g;
    end else begin
      mPrev = -1; mStreak = 0;
    end
    @(posedge clk);
    #1;
  endtask

  bit obsG0 = 0, obsG1 = 0;

  task automatic checkAgainstModel();
    int g;
    logic ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    bit ev0, ev1;
    g = refGrant();
    ew = 1'b0; ea = '0; ed = '0;
    if (g == 0) begin ew = dW0; ea = dA0; ed = dD0; end
    else if (g == 1) begin ew = dW1; ea = dA1; ed = dD1; end
    ev0 = !dRst && (mPend == 0);
    ev1 = !dRst && (mPend == 1);
    obsG0 = bus.gnt0;
    obsG1 = bus.gnt1;
    checkOutput("rnd_gnt0", 32'(bus.gnt0), 32'(g == 0));
    checkOutput("rnd_gnt1", 32'(bus.gnt1), 32'(g == 1));
    checkOutput("rnd_mem_we", 32'(bus.mem_we), 32'(ew));
    checkOutput("rnd_mem_addr", 32'(bus.mem_addr), 32'(ea));
    checkOutput("rnd_mem_din", 32'(bus.mem_din), 32'(ed));
    checkOutput("rnd_rvalid0", 32'(bus.rvalid0), 32'(ev0));
    checkOutput("rnd_rvalid1", 32'(bus.rvalid1), 32'(ev1));
    if ((ev0 || ev1) && mPendKnown) checkOutput("rnd_rdata", 32'(bus.rdata), 32'(mPendData));
  endtask

  typedef struct {
    bit rst;
    bit r0, w0; int a0, d0;
    bit r1, w1; int a1, d1;
    bit eg0, eg1, ewe, erv0, erv1;
    int erd;
  } vec_t;

  function automatic vec_t mk(bit rst, bit r0, bit w0, int a0, int d0, bit r1, bit w1, int a1, int d1,
                              bit eg0, bit eg1, bit ewe, bit erv0, bit erv1, int erd);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.erv0 = erv0; v.erv1 = erv1; v.erd = erd;
    return v;
  endfunction

  task automatic handStep(input string name, input bit r0, input bit r1, input bit eg0, input bit eg1);
    applyStimulus(0, r0, 0, 1, 0, r1, 0, 3, 0);
    checkOutput({name, "_gnt0"}, 32'(bus.gnt0), 32'(eg0));
    checkOutput({name, "_gnt1"}, 32'(bus.gnt1), 32'(eg1));
    endCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [$];
    int wait0, wait1;
    bit hold0, hold1;
    bit nr0, nw0, nr1, nw1;
    int na0, nd0, na1, nd1;

    reset = 1'b1;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    @(posedge clk);
    #1;

    //          rst r0 w0 a0 d0     r1 w1 a1 d1   g0 g1 we v0 v1 rdata
    tbl.push_back(mk(1, 1, 1, 1, 1,     0, 0, 0, 0,   1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0,     0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,   0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,     1, 1, 2, 3,   0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,     1, 1, 3, 4,   0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,     1, 0, 2, 0,   0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,     1, 0, 3, 0,   0, 1, 0, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,   0, 0, 0, 0, 1, 4));
    tbl.push_back(mk(0, 1, 1, 5, 'hAA,  0, 0, 0, 0,   1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,     1, 0, 5, 0,   0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,   0, 0, 0, 0, 1, 'hAA));
    tbl.push_back(mk(1, 1, 0, 1, 0,     1, 0, 3, 0,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0,     1, 0, 3, 0,   1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0,     1, 0, 3, 0,   1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0,     1, 0, 3, 0,   1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0,     1, 0, 3, 0,   0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0,     1, 0, 3, 0,   0, 1, 0, 0, 1, 4));
    tbl.push_back(mk(0, 1, 0, 1, 0,     1, 0, 3, 0,   0, 1, 0, 0, 1, 4));
    tbl.push_back(mk(0, 1, 0, 1, 0,     1, 0, 3, 0,   0, 1, 0, 0, 1, 4));
    tbl.push_back(mk(0, 1, 0, 1, 0,     1, 0, 3, 0,   1, 0, 0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,   0, 0, 0, 1, 0, 1));

    $display("[TB] directed vector table");
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput($sformatf("vec%0d_rst_rvalid0", i), 32'(bus.rvalid0), 32'(0));
        endCycle();
      end
      applyStimulus(0, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                    tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      checkOutput($sformatf("vec%0d_gnt0", i), 32'(bus.gnt0), 32'(tbl[i].eg0));
      checkOutput($sformatf("vec%0d_gnt1", i), 32'(bus.gnt1), 32'(tbl[i].eg1));
      checkOutput($sformatf("vec%0d_mem_we", i), 32'(bus.mem_we), 32'(tbl[i].ewe));
      checkOutput($sformatf("vec%0d_rvalid0", i), 32'(bus.rvalid0), 32'(tbl[i].erv0));
      checkOutput($sformatf("vec%0d_rvalid1", i), 32'(bus.rvalid1), 32'(tbl[i].erv1));
      if (tbl[i].erv0 || tbl[i].erv1)
        checkOutput($sformatf("vec%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].erd));
      endCycle();
    end

    $display("[TB] ownership hand-off sequence");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endCycle();
    handStep("own_a", 0, 1, 0, 1);
    handStep("own_b", 0, 1, 0, 1);
    handStep("own_c", 1, 1, 0, 1);
    handStep("own_d", 1, 1, 0, 1);
    handStep("own_e", 1, 1, 1, 0);
    handStep("own_f", 0, 1, 0, 1);
    handStep("own_g", 1, 1, 0, 1);
    handStep("own_h", 0, 0, 0, 0);
    handStep("own_i", 1, 1, 1, 0);

    $display("[TB] reset during pending read");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endCycle();
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("rst_pre_gnt0", 32'(bus.gnt0), 32'(1));
    endCycle();
    applyStimulus(1, 1, 1, 7, 'h1234, 1, 1, 9, 'h5678);
    checkOutput("rst_rvalid0", 32'(bus.rvalid0), 32'(0));
    checkOutput("rst_gnt0", 32'(bus.gnt0), 32'(0));
    checkOutput("rst_gnt1", 32'(bus.gnt1), 32'(0));
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'(0));
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
    checkOutput("rst_mem_din", 32'(bus.mem_din), 32'(0));
    endCycle();
    applyStimulus(0, 1, 0, 1, 0, 1, 0, 3, 0);
    checkOutput("post_rst_rvalid0", 32'(bus.rvalid0), 32'(0));
    checkOutput("post_rst_gnt0", 32'(bus.gnt0), 32'(1));
    checkOutput("post_rst_gnt1", 32'(bus.gnt1), 32'(0));
    endCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_rd_rvalid0", 32'(bus.rvalid0), 32'(1));
    checkOutput("post_rst_rd_rvalid1", 32'(bus.rvalid1), 32'(0));
    checkOutput("post_rst_rd_rdata", 32'(bus.rdata), 32'(1));
    endCycle();

    $display("[TB] random traffic against reference model");
    wait0 = 0; wait1 = 0;
    nr0 = 0; nw0 = 0; na0 = 0; nd0 = 0;
    nr1 = 0; nw1 = 0; na1 = 0; nd1 = 0;
    obsG0 = 0; obsG1 = 0;
    for (int i = 0; i < 800; i++) begin
      hold0 = dR0 && !obsG0 && !dRst;
      hold1 = dR1 && !obsG1 && !dRst;
      if (!hold0) begin
        nr0 = ($urandom_range(0, 3) != 0);
        nw0 = 1'($urandom_range(0, 1));
        na0 = int'($urandom_range(0, 15));
        nd0 = int'($urandom_range(0, 65535));
      end
      if (!hold1) begin
        nr1 = ($urandom_range(0, 3) != 0);
        nw1 = 1'($urandom_range(0, 1));
        na1 = int'($urandom_range(0, 15));
        nd1 = int'($urandom_range(0, 65535));
      end
      applyStimulus(($urandom_range(0, 49) == 0), nr0, nw0, na0, nd0, nr1, nw1, na1, nd1);
      checkAgainstModel();
      if (dRst) begin
        wait0 = 0; wait1 = 0;
      end else begin
        if (dR0) begin
          if (obsG0) begin
            checkOutput("starve0", 32'(wait0 <= MAX_BURST), 32'(1));
            wait0 = 0;
          end else wait0++;
        end
        if (dR1) begin
          if (obsG1) begin
            checkOutput("starve1", 32'(wait1 <= MAX_BURST), 32'(1));
            wait1 = 0;
          end else wait1++;
        end
      end
      endCycle();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares port B of the dual-port block memory (16-bit data, 10-bit word address, synchronous read, 1-cycle read latency) between two requesters: r0 (I/O / DMA engine) and r1 (display/fetch engine).
- Port A stays dedicated to the CPU and is not touched by this block.
- Grants at most one access per cycle using round-robin with a burst limit.
- Drives the memory port B signals and returns read data with a per-requester valid strobe.

Parameters:
ADDR_W, 10, memory word address width
DATA_W, 16, memory data width
MAX_BURST, 4, max consecutive grants to one requester while the other is requesting (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  r0 access request, held until gnt0
we0  in  1  r0 write enable (1=write, 0=read)
addr0  in  ADDR_W  r0 word address
wdata0  in  DATA_W  r0 write data
gnt0  out  1  r0 granted this cycle (combinational)
rvalid0  out  1  rdata holds r0 read result this cycle
req1, we1, addr1, wdata1, gnt1, rvalid1  same as r0 set, for r1
rdata  out  DATA_W  read data, shared; qualify with rvalid0/rvalid1
mem_we  out  1  to memory we_b
mem_addr  out  ADDR_W  to memory addr_b
mem_din  out  DATA_W  to memory data_b
mem_q  in  DATA_W  from memory q_b

Behaviour:
- State register with three states: IDLE, OWN0, OWN1. Also holds last_owner (1 bit), burst_cnt (clog2(MAX_BURST+1) bits), rvalid0_q and rvalid1_q.
- Reset (sync, reset=1 at edge):
  - state=IDLE, last_owner=1 (r0 wins first tie), burst_cnt=0, rvalid0/1=0.
  - While reset is high: gnt0=gnt1=0, mem_we=0, mem_addr=0, mem_din=0.
- Grant decision (combinational, same cycle as req):
  - Only reqX high: grant X.
  - Both high, state IDLE: grant the requester != last_owner.
  - Both high, state OWNx: grant x if burst_cnt < MAX_BURST, else grant the other.
  - Neither high: no grant.
  - gnt0 and gnt1 are never both 1.
- Memory drive: mem_we/mem_addr/mem_din are a mux of the granted requester's we/addr/wdata. With no grant: mem_we=0, mem_addr=0, mem_din=0.
- Next state at each edge:
  - Grant to X with state != OWNX: state=OWNX, burst_cnt=1.
  - Grant to X with state == OWNX: burst_cnt saturates at MAX_BURST.
  - Any grant sets last_owner to the granted requester.
  - No grant: state=IDLE, burst_cnt=0; last_owner is held.
- Read return:
  - rvalidX is registered and is high exactly one cycle after a cycle with gntX=1 and weX=0.
  - rdata = mem_q (pass-through).
  - A write grant never produces rvalid.
- Handshake:
  - The requester samples gnt at the clock edge.
  - The request completes on any cycle with gnt=1.
  - The requester may keep req high with new addr/we/wdata for back-to-back accesses: one access per cycle while it remains the grantee.
  - A request that is not granted must hold addr/we/wdata stable.
- Starvation bound: with both requesting continuously, each requester waits at most MAX_BURST cycles between grants.
- Reset mid-operation:
  - A read granted in the cycle before reset rises has its rvalid cleared by reset; the read result is dropped.
  - Any requests in flight are discarded; requesters re-issue after reset.
- Port A/port B same-address write collisions are the system's responsibility; this block does not detect them.

Test Plan:
1. Reset, then r0 writes addr=1, data=16'h0001 (req0 one cycle), then reads addr=1 -> gnt0 on both cycles; mem_we=1 then 0; rvalid0=1 with rdata=16'h0001 on the cycle after the read grant; rvalid1 stays 0.
2. r1 alone, back-to-back reads addr=2,3 after writing 16'h0003 and 16'h0004 -> gnt1 each cycle, no gaps; rvalid1 on consecutive cycles with rdata=3 then 4.
3. After reset, req0 and req1 rise together (reads, MAX_BURST=4) and are held -> grant sequence r0,r0,r0,r0,r1,r1,r1,r1,r0...; each rvalid appears one cycle after its own grant.
4. r1 owns the port with burst_cnt=2; r0 drops for one cycle then returns -> state returns to IDLE only when both are idle; r1 continues while it is sole requester; on contention, r0 is granted after at most MAX_BURST total r1 grants.
5. r0 read grant at cycle N with reset=1 at N+1 -> rvalid0=0 at N+1; gnt0/gnt1/mem_we=0 during reset; the first grant after reset goes to r0 on a tie.
6. Write-then-read same address from different requesters: r0 writes addr=5, data=16'h00AA; the next cycle r1 reads addr=5 -> rdata=16'h00AA with rvalid1=1 and rvalid0=0.
